log_dotp_scheduler: RTL and testbench

LOG_DOTP_SCHEDULER -- requirements
Module: log_dotp_scheduler

---
 rtl/log_dotp_scheduler.sv | 139 +++++++++++++
 tb/tb_log_dotp_scheduler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/log_dotp_scheduler.sv
// Two-requester round-robin front end for a fixed-latency log-domain dot-product datapath.
// Issued operations carry a requester tag down a LAT-deep pipe so results are routed back in order.
module log_dotp_scheduler #(
    parameter int WIDTH     = 16,
    parameter int LEN       = 8,
    parameter int LOG_WIDTH = 17,
    parameter int LAT       = 5,
    localparam int OPW      = 2*LEN*(LOG_WIDTH+2)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [OPW-1:0]   req0_opnd,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [OPW-1:0]   req1_opnd,
    output logic             req1_ready,
    input  logic             drain,
    output logic [OPW-1:0]   dp_opnd,
    output logic             dp_issue,
    input  logic [WIDTH-1:0] dp_result,
    output logic             res0_valid,
    output logic [WIDTH-1:0] res0_data,
    output logic             res1_valid,
    output logic [WIDTH-1:0] res1_data,
    output logic             busy
);

    logic             grant0_s;
    logic             grant1_s;
    logic             last_grant_r;
    logic             dp_issue_r;
    logic [OPW-1:0]   dp_opnd_r;
    logic             issue_tag_r;
    logic [LAT-1:0]   pipe_vld_r;
    logic [LAT-1:0]   pipe_tag_r;
    logic             out_vld_s;
    logic             out_tag_s;
    logic             res0_valid_r;
    logic             res1_valid_r;
    logic [WIDTH-1:0] res0_data_r;
    logic [WIDTH-1:0] res1_data_r;

    // Grant arbitration: single requester wins outright, contention goes to the one not served last.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (reset || drain) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else if (req0_valid && req1_valid) begin
            if (last_grant_r) begin
                grant0_s = 1'b1;
            end else begin
                grant1_s = 1'b1;
            end
        end else if (req0_valid) begin
            grant0_s = 1'b1;
        end else if (req1_valid) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Issue register: capture the accepted bundle and remember who was served.
    always_ff @(posedge clk) begin
        if (reset) begin
            dp_issue_r   <= 1'b0;
            dp_opnd_r    <= '0;
            issue_tag_r  <= 1'b0;
            last_grant_r <= 1'b1;
        end else if (grant0_s || grant1_s) begin
            dp_issue_r   <= 1'b1;
            dp_opnd_r    <= grant1_s ? req1_opnd : req0_opnd;
            issue_tag_r  <= grant1_s;
            last_grant_r <= grant1_s;
        end else begin
            dp_issue_r   <= 1'b0;
            dp_opnd_r    <= dp_opnd_r;
            issue_tag_r  <= issue_tag_r;
            last_grant_r <= last_grant_r;
        end
    end

    // Tag pipe: mirrors the datapath latency, never stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_vld_r <= '0;
            pipe_tag_r <= '0;
        end else begin
            pipe_vld_r[0] <= dp_issue_r;
            pipe_tag_r[0] <= issue_tag_r;
            for (int i = 1; i < LAT; i++) begin
                pipe_vld_r[i] <= pipe_vld_r[i-1];
                pipe_tag_r[i] <= pipe_tag_r[i-1];
            end
        end
    end

    assign out_vld_s = pipe_vld_r[LAT-1];
    assign out_tag_s = pipe_tag_r[LAT-1];

    // Result routing: the emerging tag picks which requester's data register captures dp_result.
    always_ff @(posedge clk) begin
        if (reset) begin
            res0_valid_r <= 1'b0;
            res1_valid_r <= 1'b0;
            res0_data_r  <= '0;
            res1_data_r  <= '0;
        end else begin
            res0_valid_r <= out_vld_s && !out_tag_s;
            res1_valid_r <= out_vld_s && out_tag_s;
            if (out_vld_s && !out_tag_s) begin
                res0_data_r <= dp_result;
            end else begin
                res0_data_r <= res0_data_r;
            end
            if (out_vld_s && out_tag_s) begin
                res1_data_r <= dp_result;
            end else begin
                res1_data_r <= res1_data_r;
            end
        end
    end

    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;
    assign dp_issue   = dp_issue_r;
    assign dp_opnd    = dp_opnd_r;
    assign res0_valid = res0_valid_r;
    assign res1_valid = res1_valid_r;
    assign res0_data  = res0_data_r;
    assign res1_data  = res1_data_r;
    // Pending captures are already represented by the last pipe stage.
    assign busy       = dp_issue_r | (|pipe_vld_r) | res0_valid_r | res1_valid_r;

endmodule

// File: tb/tb_log_dotp_scheduler.sv
// Directed self-checking bench for log_dotp_scheduler: arbitration, result routing, drain and reset.
module tb_log_dotp_scheduler;

    localparam int WIDTH     = 16;
    localparam int LEN       = 8;
    localparam int LOG_WIDTH = 17;
    localparam int LAT       = 5;
    localparam int OPW       = 2*LEN*(LOG_WIDTH+2);

    logic             clk = 1'b0;
    logic             reset;
    logic             req0_valid;
    logic [OPW-1:0]   req0_opnd;
    logic             req0_ready;
    logic             req1_valid;
    logic [OPW-1:0]   req1_opnd;
    logic             req1_ready;
    logic             drain;
    logic [OPW-1:0]   dp_opnd;
    logic             dp_issue;
    logic [WIDTH-1:0] dp_result;
    logic             res0_valid;
    logic [WIDTH-1:0] res0_data;
    logic             res1_valid;
    logic [WIDTH-1:0] res1_data;
    logic             busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [OPW-1:0] op_a;
    logic [OPW-1:0] op_b;

    log_dotp_scheduler #(.WIDTH(WIDTH), .LEN(LEN), .LOG_WIDTH(LOG_WIDTH), .LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_opnd(req0_opnd), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_opnd(req1_opnd), .req1_ready(req1_ready),
        .drain(drain), .dp_opnd(dp_opnd), .dp_issue(dp_issue), .dp_result(dp_result),
        .res0_valid(res0_valid), .res0_data(res0_data),
        .res1_valid(res1_valid), .res1_data(res1_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Advance one cycle; dp_result carries a cycle-unique value so routed data proves ordering.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        dp_result = 16'hC000 + 16'(cyc);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkop(input string tag, input logic [OPW-1:0] obs, input logic [OPW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; drain = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b1;
        req0_opnd = '0; req1_opnd = '0; dp_result = '0;
        op_a = {19{16'hA5A5}};
        op_b = {19{16'h5A3C}};

        // Reset behaviour
        tick(); tick();
        chk1("rst_ready1_low", req1_ready, 1'b0);
        reset = 1'b0; req1_valid = 1'b0;
        #1;
        chk1("rst_issue", dp_issue, 1'b0);
        chkop("rst_opnd", dp_opnd, '0);
        chk1("rst_res0_valid", res0_valid, 1'b0);
        chk1("rst_res1_valid", res1_valid, 1'b0);
        chk16("rst_res0_data", res0_data, 16'h0000);
        chk16("rst_res1_data", res1_data, 16'h0000);
        chk1("rst_busy", busy, 1'b0);
        repeat (8) tick();

        // Single req0 bundle, result 0x1234 six cycles after the handshake
        req0_valid = 1'b1; req0_opnd = op_a;
        #1;
        chk1("t1_ready0", req0_ready, 1'b1);
        chk1("t1_ready1", req1_ready, 1'b0);
        tick();
        req0_valid = 1'b0;
        chk1("t1_issue", dp_issue, 1'b1);
        chkop("t1_opnd", dp_opnd, op_a);
        chk1("t1_busy", busy, 1'b1);
        tick();
        chk1("t1_issue_off", dp_issue, 1'b0);
        chkop("t1_opnd_hold", dp_opnd, op_a);
        repeat (4) tick();
        dp_result = 16'h1234;
        chk1("t1_res0_early", res0_valid, 1'b0);
        tick();
        chk1("t1_res0_valid", res0_valid, 1'b1);
        chk16("t1_res0_data", res0_data, 16'h1234);
        chk1("t1_res1_valid", res1_valid, 1'b0);
        chk16("t1_res1_data", res1_data, 16'h0000);
        tick();
        chk1("t1_res0_off", res0_valid, 1'b0);
        chk1("t1_busy_off", busy, 1'b0);
        chk16("t1_res0_hold", res0_data, 16'h1234);

        // Contention right after reset: grants 0,1,0,1,0,1 and results in the same order
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req0_opnd = op_a; req1_opnd = op_b;
        for (int k = 0; k < 14; k++) begin
            req0_valid = (k < 6);
            req1_valid = (k < 6);
            #1;
            chk1("t2_ready0", req0_ready, (k < 6) && (k % 2 == 0));
            chk1("t2_ready1", req1_ready, (k < 6) && (k % 2 == 1));
            chk1("t2_issue", dp_issue, (k >= 1) && (k <= 6));
            if (k >= 1 && k <= 6) chkop("t2_opnd", dp_opnd, ((k - 1) % 2 == 0) ? op_a : op_b);
            chk1("t2_res0", res0_valid, (k >= 7) && (k <= 12) && ((k - 7) % 2 == 0));
            chk1("t2_res1", res1_valid, (k >= 7) && (k <= 12) && ((k - 7) % 2 == 1));
            if (k >= 7 && k <= 12)
                chk16("t2_data", ((k - 7) % 2 == 0) ? res0_data : res1_data, 16'hC000 + 16'(cyc - 1));
            tick();
        end
        chk1("t2_busy_off", busy, 1'b0);

        // Drain raised after a req0 accept: req1 blocked, in-flight result still returned
        req0_valid = 1'b1;
        #1;
        chk1("t3_ready0", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0; drain = 1'b1; req1_valid = 1'b1;
        #1;
        chk1("t3_issue", dp_issue, 1'b1);
        for (int k = 1; k < 7; k++) begin
            chk1("t3_ready1_blocked", req1_ready, 1'b0);
            tick();
        end
        chk1("t3_res0_valid", res0_valid, 1'b1);
        chk16("t3_res0_data", res0_data, 16'hC000 + 16'(cyc - 1));
        chk1("t3_busy", busy, 1'b1);
        chk1("t3_ready1_still", req1_ready, 1'b0);
        tick();
        chk1("t3_busy_off", busy, 1'b0);
        chk1("t3_res0_off", res0_valid, 1'b0);
        chk1("t3_res1_none", res1_valid, 1'b0);
        drain = 1'b0; req1_valid = 1'b0;

        // Reset three cycles after an issue discards it; req0 wins the next contention
        req0_valid = 1'b1;
        #1;
        chk1("t4_ready0", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        chk1("t4_issue", dp_issue, 1'b1);
        repeat (3) tick();
        reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk1("t4_rst_ready0", req0_ready, 1'b0);
        chk1("t4_rst_ready1", req1_ready, 1'b0);
        tick();
        reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk1("t4_issue_clr", dp_issue, 1'b0);
        chkop("t4_opnd_clr", dp_opnd, '0);
        chk16("t4_res0_data_clr", res0_data, 16'h0000);
        chk16("t4_res1_data_clr", res1_data, 16'h0000);
        chk1("t4_busy_clr", busy, 1'b0);
        for (int k = 0; k < 6; k++) begin
            chk1("t4_no_res0", res0_valid, 1'b0);
            chk1("t4_no_res1", res1_valid, 1'b0);
            tick();
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk1("t4_first_grant0", req0_ready, 1'b1);
        chk1("t4_first_grant1", req1_ready, 1'b0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        chkop("t4_opnd", dp_opnd, op_a);
        repeat (8) tick();

        // Eight back-to-back req1 accepts
        for (int k = 0; k < 17; k++) begin
            req1_valid = (k < 8);
            req1_opnd  = op_b ^ OPW'(k);
            #1;
            chk1("t5_ready1", req1_ready, (k < 8));
            chk1("t5_ready0", req0_ready, 1'b0);
            chk1("t5_issue", dp_issue, (k >= 1) && (k <= 8));
            if (k >= 1 && k <= 8) chkop("t5_opnd", dp_opnd, op_b ^ OPW'(k - 1));
            chk1("t5_res1", res1_valid, (k >= 7) && (k <= 14));
            chk1("t5_res0_never", res0_valid, 1'b0);
            if (k >= 7 && k <= 14) chk16("t5_data", res1_data, 16'hC000 + 16'(cyc - 1));
            tick();
        end
        chk1("t5_busy_off", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
